// File: rtl/i2s_top_tx_pkg.sv
// Shared definitions for the I2S transmitter: channel tags and FSM state encoding.
package i2s_top_tx_pkg;

    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous sample FIFO holding {tag, data} entries for the I2S transmitter.
module i2s_tx_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      w_level;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_level   = r_wptr - r_rptr;
    assign o_level   = w_level;
    assign o_full    = (w_level == (AW + 1)'(DEPTH));
    assign o_empty   = (w_level == '0);
    assign o_data    = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/i2s_top_tx.sv
// I2S master transmitter: SCLK divider, word/bit sequencing FSM and sample FIFO.
module i2s_top_tx
    import i2s_top_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          lr_chnl_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          sclk_o,
    output logic                          wsel_o,
    output logic                          sdat_o,
    output logic                          underrun_o,
    output logic                          sync_err_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DATA_W);

    tx_state_e         r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_div, w_div_nxt;
    logic              r_sclk, w_sclk_nxt;
    logic              r_wsel, w_wsel_nxt;
    logic [CNT_W-1:0]  r_bitcnt, w_bitcnt_nxt;
    logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
    logic              r_underrun, w_underrun_nxt;
    logic              r_sync_err, w_sync_err_nxt;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W:0]   w_head;
    logic              w_term;
    logic              w_fall;

    assign w_push = valid_i && !w_full;
    assign w_term = (r_state == ST_RUN) && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_fall = w_term && r_sclk;

    i2s_tx_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_data  ({lr_chnl_i, data_i}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level_o)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_sclk_nxt     = r_sclk;
        w_wsel_nxt     = r_wsel;
        w_bitcnt_nxt   = r_bitcnt;
        w_shreg_nxt    = r_shreg;
        w_underrun_nxt = 1'b0;
        w_sync_err_nxt = 1'b0;
        w_pop          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_div_nxt    = '0;
                w_sclk_nxt   = 1'b0;
                w_wsel_nxt   = I2S_LEFT;
                w_bitcnt_nxt = '0;
                w_shreg_nxt  = '0;
                if (enable_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_term) begin
                    w_div_nxt  = '0;
                    w_sclk_nxt = !r_sclk;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
                if (w_fall) begin
                    if (r_bitcnt == '0) begin
                        // Bit counter at zero marks a word-load tick.
                        if ((r_wsel == I2S_LEFT) && !enable_i) begin
                            w_state_nxt = ST_IDLE;
                            w_shreg_nxt = '0;
                        end else begin
                            w_bitcnt_nxt = CNT_W'(DATA_W - 1);
                            if (w_empty) begin
                                w_shreg_nxt    = '0;
                                w_underrun_nxt = 1'b1;
                            end else begin
                                w_pop = 1'b1;
                                if (w_head[DATA_W] != r_wsel) begin
                                    w_shreg_nxt    = '0;
                                    w_sync_err_nxt = 1'b1;
                                end else begin
                                    w_shreg_nxt = w_head[DATA_W-1:0];
                                end
                            end
                        end
                    end else begin
                        w_bitcnt_nxt = r_bitcnt - 1'b1;
                        w_shreg_nxt  = {r_shreg[DATA_W-2:0], 1'b0};
                        if (r_bitcnt == CNT_W'(1)) begin
                            w_wsel_nxt = (r_wsel == I2S_LEFT) ? I2S_RIGHT : I2S_LEFT;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_sclk     <= 1'b0;
            r_wsel     <= I2S_LEFT;
            r_bitcnt   <= '0;
            r_shreg    <= '0;
            r_underrun <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_sclk     <= w_sclk_nxt;
            r_wsel     <= w_wsel_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_shreg    <= w_shreg_nxt;
            r_underrun <= w_underrun_nxt;
            r_sync_err <= w_sync_err_nxt;
        end
    end

    assign ready_o    = !w_full;
    assign sclk_o     = r_sclk;
    assign wsel_o     = r_wsel;
    assign sdat_o     = r_shreg[DATA_W-1];
    assign underrun_o = r_underrun;
    assign sync_err_o = r_sync_err;

endmodule

// File: tb/tb_i2s_top_tx.sv
// Self-checking bench for i2s_top_tx: per-cycle comparison against a slot/tick arithmetic model.
module tb_i2s_top_tx;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              enable_i = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic              lr_chnl_i = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic              sclk_o;
    logic              wsel_o;
    logic              sdat_o;
    logic              underrun_o;
    logic              sync_err_o;
    logic [LVL_W-1:0]  level_o;

    int n_checks = 0;
    int n_err    = 0;

    i2s_top_tx #(
        .DATA_W     (DATA_W),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .data_i     (data_i),
        .lr_chnl_i  (lr_chnl_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .sclk_o     (sclk_o),
        .wsel_o     (wsel_o),
        .sdat_o     (sdat_o),
        .underrun_o (underrun_o),
        .sync_err_o (sync_err_o),
        .level_o    (level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) begin
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
            end
        end
    endtask

    // Model: time since run start determines SCLK phase, tick index, slot and bit.
    bit                m_run  = 1'b0;
    int                m_k    = 0;
    logic [DATA_W:0]   m_q[$];
    logic [DATA_W-1:0] m_word = '0;
    logic              e_sclk = 1'b0;
    logic              e_wsel = 1'b0;
    logic              e_sdat = 1'b0;
    logic              e_und  = 1'b0;
    logic              e_sync = 1'b0;

    task automatic model_step();
        bit              full_before;
        int              n, s, b;
        logic [DATA_W:0] h;
        if (!rst_i) begin
            m_run = 1'b0; m_k = 0; m_q.delete(); m_word = '0;
            e_sclk = 1'b0; e_wsel = 1'b0; e_sdat = 1'b0; e_und = 1'b0; e_sync = 1'b0;
            return;
        end
        full_before = (m_q.size() >= FIFO_DEPTH);
        e_und  = 1'b0;
        e_sync = 1'b0;
        if (!m_run) begin
            if (enable_i) begin
                m_run = 1'b1;
                m_k   = 0;
            end
        end else begin
            m_k++;
            e_sclk = ((m_k / CLK_DIV) % 2) != 0;
            if ((m_k % (2 * CLK_DIV)) == 0) begin
                n = m_k / (2 * CLK_DIV) - 1;
                s = n / DATA_W;
                b = n % DATA_W;
                if (b == 0 && (s % 2) == 0 && !enable_i) begin
                    m_run = 1'b0; e_sclk = 1'b0; e_sdat = 1'b0; e_wsel = 1'b0;
                end else begin
                    if (b == 0) begin
                        if (m_q.size() == 0) begin
                            m_word = '0;
                            e_und  = 1'b1;
                        end else begin
                            h = m_q.pop_front();
                            if (h[DATA_W] != ((s % 2) != 0)) begin
                                m_word = '0;
                                e_sync = 1'b1;
                            end else begin
                                m_word = h[DATA_W-1:0];
                            end
                        end
                    end
                    e_sdat = m_word[DATA_W-1-b];
                    e_wsel = (((n + 1) / DATA_W) % 2) != 0;
                end
            end
        end
        if (valid_i && !full_before) begin
            m_q.push_back({lr_chnl_i, data_i});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            model_step();
            #1;
            check("sclk", 32'(sclk_o), 32'(e_sclk));
            check("wsel", 32'(wsel_o), 32'(e_wsel));
            check("sdat", 32'(sdat_o), 32'(e_sdat));
            check("underrun", 32'(underrun_o), 32'(e_und));
            check("sync_err", 32'(sync_err_o), 32'(e_sync));
            check("ready", 32'(ready_o), 32'(m_q.size() < FIFO_DEPTH));
            check("level", 32'(level_o), 32'(m_q.size()));
        end
    end

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0; enable_i = 1'b0; valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic push(input logic tag, input logic [DATA_W-1:0] d);
        valid_i = 1'b1; lr_chnl_i = tag; data_i = d;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    // I2S-style capture: sample SD on each SCLK rise.
    task automatic rx_bits(input int nbits, output logic [63:0] bits, output int und);
        logic prev;
        int   got;
        prev = sclk_o; bits = '0; und = 0; got = 0;
        for (int c = 0; c < nbits * 2 * CLK_DIV + 20 && got < nbits; c++) begin
            @(posedge clk_i); #1;
            if (underrun_o) und++;
            if (sclk_o && !prev) begin
                bits = {bits[62:0], sdat_o};
                got++;
            end
            prev = sclk_o;
        end
        check("rx_bit_count", 32'(got), 32'(nbits));
    endtask

    task automatic count_flags(input int ncyc, output int und, output int syn);
        und = 0; syn = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk_i); #1;
            if (underrun_o) und++;
            if (sync_err_o) syn++;
        end
    endtask

    initial begin
        logic [63:0] bits;
        int          und, syn, first;
        logic        tag;

        // Reset / idle
        do_reset();
        repeat (200) @(negedge clk_i);
        check("idle_sclk", 32'(sclk_o), 32'd0);
        check("idle_wsel", 32'(wsel_o), 32'd0);
        check("idle_sdat", 32'(sdat_o), 32'd0);
        check("idle_ready", 32'(ready_o), 32'd1);
        check("idle_level", 32'(level_o), 32'd0);

        // Basic frame
        do_reset();
        push(1'b0, 16'hA5C3);
        push(1'b1, 16'h3C5A);
        enable_i = 1'b1;
        @(posedge clk_i);
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_i); #1;
            if (sdat_o) begin first = k; break; end
        end
        check("first_fall_tick", 32'(first), 32'd4);
        rx_bits(32, bits, und);
        check("frame_left", 32'(bits[31:16]), 32'hA5C3);
        check("frame_right", 32'(bits[15:0]), 32'h3C5A);
        check("frame_underruns", 32'(und), 32'd0);
        @(negedge clk_i);
        enable_i = 1'b0;
        repeat (150) @(negedge clk_i);

        // Underrun, then a late left word
        do_reset();
        enable_i = 1'b1;
        count_flags(256, und, syn);
        check("underrun_count", 32'(und), 32'd4);
        check("underrun_sync", 32'(syn), 32'd0);
        @(negedge clk_i);
        push(1'b0, 16'h8001);
        first = -1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk_i); #1;
            if (sdat_o) begin first = k; break; end
        end
        check("late_left_ws", 32'(wsel_o), 32'd0);
        check("late_left_seen", 32'(first >= 0), 32'd1);
        rx_bits(16, bits, und);
        check("late_left_word", 32'(bits[15:0]), 32'h8001);
        @(negedge clk_i);
        enable_i = 1'b0;
        repeat (200) @(negedge clk_i);

        // Sync error
        do_reset();
        push(1'b1, 16'h1234);
        push(1'b0, 16'h5678);
        push(1'b1, 16'h9ABC);
        enable_i = 1'b1;
        count_flags(256, und, syn);
        check("sync_count", 32'(syn), 32'd3);
        check("sync_underrun", 32'(und), 32'd1);
        check("sync_level", 32'(level_o), 32'd0);
        @(negedge clk_i);
        enable_i = 1'b0;
        repeat (200) @(negedge clk_i);

        // Backpressure
        do_reset();
        valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lr_chnl_i = i[0];
            data_i    = DATA_W'(16'h1000 + i);
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        check("bp_level", 32'(level_o), 32'd4);
        check("bp_ready", 32'(ready_o), 32'd0);
        enable_i = 1'b1;
        @(posedge clk_i);
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_i); #1;
            if (ready_o) begin first = k; break; end
        end
        check("bp_ready_return", 32'(first), 32'd4);
        repeat (300) @(negedge clk_i);
        enable_i = 1'b0;
        repeat (200) @(negedge clk_i);

        // Stop mid-frame, then asynchronous reset mid-bit
        do_reset();
        push(1'b0, 16'h1111);
        push(1'b1, 16'h2222);
        push(1'b0, 16'h3333);
        push(1'b1, 16'h4444);
        enable_i = 1'b1;
        repeat (30) @(negedge clk_i);
        enable_i = 1'b0;
        repeat (200) @(negedge clk_i);
        check("stop_sclk", 32'(sclk_o), 32'd0);
        check("stop_wsel", 32'(wsel_o), 32'd0);
        check("stop_sdat", 32'(sdat_o), 32'd0);
        check("stop_level", 32'(level_o), 32'd2);
        enable_i = 1'b1;
        repeat (41) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("arst_sclk", 32'(sclk_o), 32'd0);
        check("arst_wsel", 32'(wsel_o), 32'd0);
        check("arst_sdat", 32'(sdat_o), 32'd0);
        check("arst_ready", 32'(ready_o), 32'd1);
        check("arst_level", 32'(level_o), 32'd0);
        check("arst_flags", 32'({underrun_o, sync_err_o}), 32'd0);
        @(negedge clk_i);
        enable_i = 1'b0;
        rst_i    = 1'b1;

        // Randomized traffic with occasional mis-tags and enable toggles
        do_reset();
        enable_i = 1'b1;
        tag = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            valid_i   = ($urandom_range(0, 3) == 0);
            lr_chnl_i = tag ^ ($urandom_range(0, 15) == 0);
            data_i    = DATA_W'($urandom);
            if (valid_i && ready_o) tag = !tag;
            if ($urandom_range(0, 499) == 0) enable_i = !enable_i;
            @(negedge clk_i);
        end
        valid_i  = 1'b0;
        enable_i = 1'b0;
        repeat (200) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
